lsu_sequencer: RTL
==================

Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the decoder/regfile datapath and a single 32-bit data memory port.
- Takes the decoder's 4-bit LSU control plus the effective address and store data. Issues one or two word-aligned bus beats, merges and extends load data, and stalls the program counter until the access completes.
- Splits misaligned word and half accesses into two aligned beats, or faults them, depending on a parameter.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = misaligned accesses become two beats; 0 = misaligned accesses fault with no bus activity.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lsu_ctrl  in  4  [1:0] width: 00 none, 01 word, 10 half, 11 byte; [2] 1 = store; [3] 1 = zero-extend load
- addr  in  32  effective byte address (rs1 + imm)
- store_data  in  32  rs2 value; low bytes are used for half/byte stores
- stall  out  1  hold PC and suppress regfile write while 1
- load_valid  out  1  load_data valid this cycle; regfile write enable for loads
- load_data  out  32  extended load result
- misaligned  out  1  one-cycle fault pulse (SPLIT_MISALIGNED=0 only)
- mem_valid  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned bus address, [1:0]=00
- mem_wstrb  out  4  byte write strobes; 0000 on reads
- mem_wdata  out  32  bus write data
- mem_rdata  in  32  bus read data, valid in the mem_ready cycle
- mem_ready  in  1  bus accepts and completes the beat this cycle

Behaviour:
- Reset values (async): state IDLE; mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0; load_valid=0, load_data=0, misaligned=0. stall is combinational and evaluates to 0 in IDLE with width=00.
- Terms: n = bytes (4/2/1); o = addr[1:0].
- An access is misaligned when (word and o!=0) or (half and o==3).
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE, width!=00:
  - stall=1 combinationally.
  - If aligned, or misaligned with SPLIT=1: register beat-0 outputs; next state BEAT0.
  - If misaligned with SPLIT=0: misaligned=1 and stall=0 in the same cycle; stay in IDLE; no bus beat; no load_valid.
- IDLE, width=00: stall=0; nothing happens.
- BEAT0:
  - stall=1; mem_valid=1.
  - mem_addr = {addr[31:2],2'b00}.
  - mem_wstrb = bytes o..min(3,o+n-1) on stores.
  - mem_wdata = low word of (store_data << 8*o), computed over 64 bits.
  - On mem_ready: capture mem_rdata into lo. If split, go to BEAT1, else go to DONE.
- BEAT1:
  - mem_addr = beat-0 address + 4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000).
  - mem_wstrb = bytes 0..(o+n-5).
  - mem_wdata = high word of the shifted value.
  - On mem_ready: capture hi; go to DONE.
- DONE:
  - stall=0.
  - For loads: load_valid=1 and load_data = n bytes of ({hi,lo} >> 8*o), sign- or zero-extended per lsu_ctrl[3]. Word loads ignore lsu_ctrl[3].
  - For stores: load_valid=0.
  - Next state IDLE unconditionally; the PC advances at this edge.
- Handshake: mem_valid, mem_we, mem_addr, mem_wstrb and mem_wdata are registered and must stay stable from assertion until the cycle mem_ready=1. mem_ready while mem_valid=0 is ignored.
- After the final beat accepts, mem_valid drops on the next edge. No idle gap between BEAT0 and BEAT1.
- Latency: aligned access = 2 + wait cycles of stall, with load_valid in the 3rd cycle. Split access adds 1 + its wait cycles.
- Inputs lsu_ctrl, addr and store_data are held by the core while stall=1. The sequencer still latches o, n, store and zero-extend at IDLE exit and uses only the latched copies.
- Back-to-back memory instructions: DONE→IDLE→BEAT0; each access re-enters through IDLE.
- Reset mid-operation: immediate return to IDLE with mem_valid=0. A partial split store may already have written beat 0; this is accepted behaviour.

Test Plan:
- Aligned word load, addr=0x100, mem_rdata=0xDEADBEEF, mem_ready=1 at first request → one beat at 0x100, wstrb=0000; stall for 2 cycles; load_valid with load_data=0xDEADBEEF in cycle 3.
- Byte load signed, addr=0x203, rdata=0x80xxxxxx → load_data=0xFFFFFF80. With lsu_ctrl[3]=1 → 0x00000080.
- Half store, addr=0x302, store_data=0x1234ABCD → one beat at 0x300, wstrb=1100, wdata[31:16]=0xABCD.
- SPLIT=1 word store, addr=0x401, data=0x11223344 → beat0 at 0x400 with wstrb=1110, wdata=0x22334400; beat1 at 0x404 with wstrb=0001, wdata=0x00000011. Load of the same layout returns 0x11223344.
- Wait states: mem_ready low for 3 cycles in BEAT0 → outputs held constant, stall held; completion 3 cycles later.
- Async reset asserted in BEAT1 → mem_valid=0 and state IDLE before the next edge. SPLIT=0 word at 0x402 → misaligned pulse, no mem_valid.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: turns one decoded LSU op into one or two aligned
// 32-bit bus beats, merges/extends load data, and stalls the PC meanwhile.
// Ports:
//   clk, rst (async, active-high)
//   lsu_ctrl, addr, store_data : op from decode/regfile, held while stall=1
//   stall, load_valid, load_data, misaligned : back to the core
//   mem_valid/we/addr/wstrb/wdata : registered bus request
//   mem_rdata, mem_ready : bus response
module lsu_sequencer #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  lsu_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_o;
  logic [1:0]  r_width;
  logic        r_store;
  logic        r_zext;
  logic        r_split;
  logic [3:0]  r_strb_hi;
  logic [31:0] r_wdata_hi;
  logic [31:0] r_lo;

  logic [1:0]  w_width;
  logic [1:0]  w_o;
  logic        w_req;
  logic        w_mis;
  logic        w_fault;
  logic        w_go;
  logic [3:0]  w_nmask;
  logic [7:0]  w_strb8;
  logic [63:0] w_sh;
  logic [63:0] w_merge;
  logic        w_last;

  assign w_width = lsu_ctrl[1:0];
  assign w_o     = addr[1:0];
  assign w_req   = |w_width;
  assign w_mis   = (w_width == 2'b01 && w_o != 2'b00) ||
                   (w_width == 2'b10 && w_o == 2'b11);
  assign w_fault = w_req && w_mis && !SPLIT_MISALIGNED;
  assign w_go    = w_req && !w_fault;

  always_comb begin
    w_nmask = 4'b0001;
    unique case (w_width)
      2'b01:   w_nmask = 4'b1111;
      2'b10:   w_nmask = 4'b0011;
      default: w_nmask = 4'b0001;
    endcase
  end

  // Strobes and data laid out over two words; upper half feeds beat 1.
  assign w_strb8 = {4'b0000, w_nmask} << w_o;
  assign w_sh    = {32'd0, store_data} << {w_o, 3'b000};

  // Beat-1 read data arrives live; beat-0 data was parked in r_lo.
  assign w_merge = (r_state == BEAT1) ? {mem_rdata, r_lo}
                                      : {32'd0, mem_rdata};
  assign w_last  = mem_ready &&
                   ((r_state == BEAT0 && !r_split) || r_state == BEAT1);

  function automatic logic [31:0] f_ext(
    input logic [63:0] v,
    input logic [1:0]  o,
    input logic [1:0]  w,
    input logic        z
  );
    logic [63:0] s;
    s = v >> {o, 3'b000};
    unique case (w)
      2'b11:   f_ext = z ? {24'd0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'b10:   f_ext = z ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: f_ext = s[31:0];
    endcase
  endfunction

  always_comb begin
    stall = 1'b1;
    unique case (r_state)
      IDLE:    stall = w_go;
      DONE:    stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  // Fault is reported in the request cycle so the PC can trap right away.
  assign misaligned = !rst && (r_state == IDLE) && w_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_o        <= 2'b00;
      r_width    <= 2'b00;
      r_store    <= 1'b0;
      r_zext     <= 1'b0;
      r_split    <= 1'b0;
      r_strb_hi  <= 4'b0000;
      r_wdata_hi <= 32'd0;
      r_lo       <= 32'd0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'd0;
      load_valid <= 1'b0;
      load_data  <= 32'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          load_valid <= 1'b0;
          if (w_go) begin
            r_o        <= w_o;
            r_width    <= w_width;
            r_store    <= lsu_ctrl[2];
            r_zext     <= lsu_ctrl[3];
            r_split    <= |w_strb8[7:4];
            r_strb_hi  <= w_strb8[7:4];
            r_wdata_hi <= w_sh[63:32];
            mem_valid  <= 1'b1;
            mem_we     <= lsu_ctrl[2];
            mem_addr   <= {addr[31:2], 2'b00};
            mem_wstrb  <= lsu_ctrl[2] ? w_strb8[3:0] : 4'b0000;
            mem_wdata  <= w_sh[31:0];
            r_state    <= BEAT0;
          end
        end
        BEAT0, BEAT1: begin
          if (w_last) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
            load_valid <= !r_store;
            if (!r_store)
              load_data <= f_ext(w_merge, r_o, r_width, r_zext);
            r_state    <= DONE;
          end else if (mem_ready) begin
            r_lo      <= mem_rdata;
            mem_addr  <= mem_addr + 32'd4;
            mem_wstrb <= r_store ? r_strb_hi : 4'b0000;
            mem_wdata <= r_wdata_hi;
            r_state   <= BEAT1;
          end
        end
        DONE: begin
          load_valid <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
